// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM state, count direction and
// the operation the FSM requests from the counter datapath.
package counter_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_STEP = 2'd2
    } count_op_t;

endpackage

// File: rtl/counter_datapath.sv
// Count register with load mux, +/-1 step (wraps modulo 2^WIDTH) and an
// equality compare against the terminal value.
module counter_datapath
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  count_op_t        op_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] end_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_end_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        case (op_i)
            OP_LOAD: count_d = load_val_i;
            OP_STEP: count_d = (dir_i == DIR_DOWN) ? count_q - WIDTH'(1)
                                                   : count_q + WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_end_o = (count_q == end_val_i);

endmodule

// File: rtl/counter_sequencer.sv
// Configurable start/end/direction counter run by go/pause/abort commands,
// with terminal-count flag and a one-cycle completion pulse.
//
//   state | meaning
//   IDLE  | waiting for a configuration
//   ARMED | configured, count = start, waiting for go
//   RUN   | counting one step per cycle
//   PAUSE | count frozen, go resumes
//   DONE  | one-shot finished, single-cycle pulse
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_end,
    input  logic             cfg_dir,
    input  logic             cfg_reload,
    input  logic             go,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             paused,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] start_q, end_q;
    logic             dir_q, reload_q;
    logic             latch_cfg;
    count_op_t        op;
    logic [WIDTH-1:0] load_val;
    logic             at_end;

    always_comb begin
        state_d   = state_q;
        op        = OP_HOLD;
        load_val  = start_q;
        latch_cfg = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    latch_cfg = 1'b1;
                    op        = OP_LOAD;
                    load_val  = cfg_start;
                    state_d   = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cfg_valid) begin
                    latch_cfg = 1'b1;
                    op        = OP_LOAD;
                    load_val  = cfg_start;
                end else if (go) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort beats pause, pause beats the terminal action
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (at_end) begin
                    if (reload_q) begin
                        op = OP_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    op = OP_STEP;
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (go) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            start_q  <= '0;
            end_q    <= '0;
            dir_q    <= DIR_UP;
            reload_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_cfg) begin
                start_q  <= cfg_start;
                end_q    <= cfg_end;
                dir_q    <= cfg_dir;
                reload_q <= cfg_reload;
            end
        end
    end

    counter_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk        (clk),
        .rst        (reset),
        .op_i       (op),
        .load_val_i (load_val),
        .dir_i      (dir_q),
        .end_val_i  (end_q),
        .count_o    (count),
        .at_end_o   (at_end)
    );

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_ARMED);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign paused    = (state_q == ST_PAUSE);
    assign done      = (state_q == ST_DONE);
    assign tc        = (state_q == ST_RUN) && at_end;

endmodule
